enc_in_ctrl: RTL and testbench

- Sequencer and host-access controller for the encoder-input measurement block.
- Takes coherent snapshots of the four 32-bit measurement results plus direction.
- Serves the snapshots as 16-bit words to the host bus, and sequences the `reset_enc_in_counts` pulse.
- Arbitrates between host commands and a periodic auto-snapshot timer, so the host never reads torn 32-bit values.

---
 rtl/enc_in_ctrl_pkg.sv | 47 ++++
 rtl/enc_in_sample_timer.sv | 42 ++++
 rtl/enc_in_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_enc_in_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_in_ctrl_pkg.sv
// Shared types and constants for the encoder-input controller: FSM states,
// host command codes, read address map and status word layout.
package enc_in_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int WORD_W = 16;
    localparam int SEQ_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SNAP     = 3'd1,
        ST_RD       = 3'd2,
        ST_CLR      = 3'd3,
        ST_CLR_WAIT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CMD_SNAP = 2'b00,
        CMD_CLR  = 2'b01,
        CMD_RD   = 2'b10,
        CMD_RSVD = 2'b11
    } host_cmd_t;

    localparam logic [3:0] ADDR_PERIOD_LO  = 4'd0;
    localparam logic [3:0] ADDR_PERIOD_HI  = 4'd1;
    localparam logic [3:0] ADDR_ONTIME_LO  = 4'd2;
    localparam logic [3:0] ADDR_ONTIME_HI  = 4'd3;
    localparam logic [3:0] ADDR_IPERIOD_LO = 4'd4;
    localparam logic [3:0] ADDR_IPERIOD_HI = 4'd5;
    localparam logic [3:0] ADDR_COUNTS_LO  = 4'd6;
    localparam logic [3:0] ADDR_COUNTS_HI  = 4'd7;
    localparam logic [3:0] ADDR_STATUS     = 4'd8;
    localparam logic [3:0] ADDR_DELTA_LO   = 4'd9;
    localparam logic [3:0] ADDR_DELTA_HI   = 4'd10;

    localparam int STAT_DIR     = 0;
    localparam int STAT_PEND    = 1;
    localparam int STAT_AUTO_EN = 2;
    localparam int STAT_ERR     = 3;
    localparam int STAT_SEQ_LSB = 8;

    function automatic logic [WORD_W-1:0] half_word(input logic [DATA_W-1:0] v,
                                                    input logic hi);
        return hi ? v[DATA_W-1:WORD_W] : v[WORD_W-1:0];
    endfunction

endpackage

// File: rtl/enc_in_sample_timer.sv
// Auto-snapshot interval timer: raises auto_pending on each terminal count and
// flags a tick that arrives while a previous request is still unserviced.
module enc_in_sample_timer
    import enc_in_ctrl_pkg::*;
#(
    parameter int TIMER_W = 24
) (
    input  logic               xclk,
    input  logic               reset,
    input  logic               auto_en,
    input  logic [TIMER_W-1:0] sample_interval,
    input  logic               pend_clr,
    output logic               auto_pending,
    output logic               tick_drop
);

    logic [TIMER_W-1:0] count;
    logic               enabled;
    logic               tick;

    assign enabled   = auto_en && (sample_interval != '0);
    assign tick      = enabled && (count == sample_interval - TIMER_W'(1));
    assign tick_drop = tick && auto_pending && !pend_clr;

    // A shrunk interval that the count already passed restarts quietly at 0.
    always_ff @(posedge xclk or negedge reset) begin
        if (!reset) begin
            count        <= '0;
            auto_pending <= 1'b0;
        end else if (!enabled) begin
            count        <= '0;
            auto_pending <= 1'b0;
        end else begin
            if (tick || (count >= sample_interval))
                count <= '0;
            else
                count <= count + TIMER_W'(1);
            auto_pending <= tick || (auto_pending && !pend_clr);
        end
    end

endmodule

// File: rtl/enc_in_ctrl.sv
// Snapshot sequencer and 16-bit host window over the encoder measurements.
// Define ENC_IN_CTRL_DELTA_EN to add the per-snapshot count delta at addr 9/10.
module enc_in_ctrl
    import enc_in_ctrl_pkg::*;
#(
    parameter int CLR_PULSE_CYCLES = 2,
    parameter int TIMER_W          = 24
) (
    input  logic               xclk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  enc_period,
    input  logic [DATA_W-1:0]  enca_ontime,
    input  logic [DATA_W-1:0]  enci_period,
    input  logic [DATA_W-1:0]  enc_counts,
    input  logic               enc_dir,
    output logic               reset_enc_in_counts,
    input  logic               host_req,
    input  logic [1:0]         host_cmd,
    input  logic [3:0]         host_addr,
    output logic               host_ready,
    output logic               host_ack,
    output logic [WORD_W-1:0]  host_rdata,
    input  logic               auto_en,
    input  logic [TIMER_W-1:0] sample_interval
);

    localparam logic [3:0] CLR_LAST      = 4'(CLR_PULSE_CYCLES - 1);
    localparam logic [3:0] CLR_WAIT_LAST = 4'd1;

    state_t              state, state_nx;
    logic [3:0]          cnt, cnt_nx;
    logic                snap_auto, snap_auto_nx;
    logic                ack_nx, snap_en, rd_en, pend_clr;
    logic                err, err_set, err_clr;
    logic                auto_pending, tick_drop;
    logic [SEQ_W-1:0]    snap_seq;
    logic [3:0]          addr_q;
    logic [DATA_W-1:0]   period_sh, ontime_sh, iperiod_sh, counts_sh;
    logic                dir_sh;
    logic signed [DATA_W-1:0] delta_q;
    logic [WORD_W-1:0]   status_word, rd_word;

    enc_in_sample_timer #(.TIMER_W(TIMER_W)) u_timer (
        .xclk            (xclk),
        .reset           (reset),
        .auto_en         (auto_en),
        .sample_interval (sample_interval),
        .pend_clr        (pend_clr),
        .auto_pending    (auto_pending),
        .tick_drop       (tick_drop)
    );

    always_ff @(posedge xclk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            snap_auto <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            snap_auto <= snap_auto_nx;
        end
    end

    // Host requests beat a pending auto snapshot; the pending flag survives.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt + 4'd1;
        snap_auto_nx = snap_auto;
        case (state)
            ST_IDLE: begin
                cnt_nx = '0;
                if (host_req) begin
                    case (host_cmd)
                        CMD_SNAP: begin
                            state_nx     = ST_SNAP;
                            snap_auto_nx = 1'b0;
                        end
                        CMD_CLR: state_nx = ST_CLR;
                        CMD_RD:  state_nx = ST_RD;
                        default: state_nx = ST_IDLE;
                    endcase
                end else if (auto_pending) begin
                    state_nx     = ST_SNAP;
                    snap_auto_nx = 1'b1;
                end
            end
            ST_SNAP, ST_RD: state_nx = ST_IDLE;
            ST_CLR: begin
                if (cnt == CLR_LAST) begin
                    state_nx = ST_CLR_WAIT;
                    cnt_nx   = '0;
                end
            end
            ST_CLR_WAIT: if (cnt == CLR_WAIT_LAST) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        host_ready = (state == ST_IDLE);
        snap_en    = (state == ST_SNAP);
        rd_en      = (state == ST_RD);
        pend_clr   = snap_en && snap_auto;
        case (state)
            ST_IDLE:     ack_nx = host_req && (host_cmd == CMD_RSVD);
            ST_SNAP:     ack_nx = !snap_auto;
            ST_RD:       ack_nx = 1'b1;
            ST_CLR_WAIT: ack_nx = (cnt == CLR_WAIT_LAST);
            default:     ack_nx = 1'b0;
        endcase
    end

    assign err_set = (host_req && !host_ready) || tick_drop;
    assign err_clr = rd_en && (addr_q == ADDR_STATUS);

    // The clear pulse is registered off next-state so reset drops it at once.
    always_ff @(posedge xclk or negedge reset) begin
        if (!reset) begin
            host_ack            <= 1'b0;
            reset_enc_in_counts <= 1'b0;
            err                 <= 1'b0;
            snap_seq            <= '0;
        end else begin
            host_ack            <= ack_nx;
            reset_enc_in_counts <= (state_nx == ST_CLR);
            if (err_set)
                err <= 1'b1;
            else if (err_clr)
                err <= 1'b0;
            if (snap_en)
                snap_seq <= snap_seq + SEQ_W'(1);
        end
    end

    always_ff @(posedge xclk or negedge reset) begin
        if (!reset) begin
            addr_q     <= '0;
            period_sh  <= '0;
            ontime_sh  <= '0;
            iperiod_sh <= '0;
            counts_sh  <= '0;
            dir_sh     <= 1'b0;
            host_rdata <= '0;
        end else begin
            if (host_ready && host_req)
                addr_q <= host_addr;
            if (snap_en) begin
                period_sh  <= enc_period;
                ontime_sh  <= enca_ontime;
                iperiod_sh <= enci_period;
                counts_sh  <= enc_counts;
                dir_sh     <= enc_dir;
            end
            if (rd_en)
                host_rdata <= rd_word;
        end
    end

`ifdef ENC_IN_CTRL_DELTA_EN
    logic signed [DATA_W-1:0] delta_ref;

    // The reference is separate from counts_sh so a clear can zero it.
    always_ff @(posedge xclk or negedge reset) begin
        if (!reset) begin
            delta_q   <= '0;
            delta_ref <= '0;
        end else if (snap_en) begin
            delta_q   <= $signed(enc_counts) - delta_ref;
            delta_ref <= $signed(enc_counts);
        end else if (state == ST_CLR) begin
            delta_ref <= '0;
        end
    end
`else
    assign delta_q = '0;
`endif

    always_comb begin
        status_word                            = '0;
        status_word[STAT_SEQ_LSB +: SEQ_W]     = snap_seq;
        status_word[STAT_ERR]                  = err;
        status_word[STAT_AUTO_EN]              = auto_en;
        status_word[STAT_PEND]                 = auto_pending;
        status_word[STAT_DIR]                  = dir_sh;
    end

    always_comb begin
        case (addr_q)
            ADDR_PERIOD_LO:  rd_word = half_word(period_sh, 1'b0);
            ADDR_PERIOD_HI:  rd_word = half_word(period_sh, 1'b1);
            ADDR_ONTIME_LO:  rd_word = half_word(ontime_sh, 1'b0);
            ADDR_ONTIME_HI:  rd_word = half_word(ontime_sh, 1'b1);
            ADDR_IPERIOD_LO: rd_word = half_word(iperiod_sh, 1'b0);
            ADDR_IPERIOD_HI: rd_word = half_word(iperiod_sh, 1'b1);
            ADDR_COUNTS_LO:  rd_word = half_word(counts_sh, 1'b0);
            ADDR_COUNTS_HI:  rd_word = half_word(counts_sh, 1'b1);
            ADDR_STATUS:     rd_word = status_word;
            ADDR_DELTA_LO:   rd_word = half_word(delta_q, 1'b0);
            ADDR_DELTA_HI:   rd_word = half_word(delta_q, 1'b1);
            default:         rd_word = '0;
        endcase
    end

endmodule

// File: tb/tb_enc_in_ctrl.sv
// Bench for enc_in_ctrl: directed vector table, multi-cycle corner sequences
// and randomized host traffic against a behavioural model.
module tb_enc_in_ctrl;
    import enc_in_ctrl_pkg::*;

    localparam int CLR_P = 2;
    localparam int TW    = 24;

`ifdef ENC_IN_CTRL_DELTA_EN
    localparam bit        DELTA_ON = 1'b1;
    localparam logic [15:0] T_D9  = 16'hFFFE;
    localparam logic [15:0] T_D10 = 16'hFFFF;
`else
    localparam bit        DELTA_ON = 1'b0;
    localparam logic [15:0] T_D9  = 16'h0000;
    localparam logic [15:0] T_D10 = 16'h0000;
`endif

    logic          xclk = 1'b0;
    logic          reset = 1'b0;
    logic [31:0]   enc_period, enca_ontime, enci_period, enc_counts;
    logic          enc_dir;
    logic          reset_enc_in_counts;
    logic          host_req;
    logic [1:0]    host_cmd;
    logic [3:0]    host_addr;
    logic          host_ready, host_ack;
    logic [15:0]   host_rdata;
    logic          auto_en;
    logic [TW-1:0] sample_interval;

    enc_in_ctrl #(.CLR_PULSE_CYCLES(CLR_P), .TIMER_W(TW)) dut (
        .xclk                (xclk),
        .reset               (reset),
        .enc_period          (enc_period),
        .enca_ontime         (enca_ontime),
        .enci_period         (enci_period),
        .enc_counts          (enc_counts),
        .enc_dir             (enc_dir),
        .reset_enc_in_counts (reset_enc_in_counts),
        .host_req            (host_req),
        .host_cmd            (host_cmd),
        .host_addr           (host_addr),
        .host_ready          (host_ready),
        .host_ack            (host_ack),
        .host_rdata          (host_rdata),
        .auto_en             (auto_en),
        .sample_interval     (sample_interval)
    );

    always #5 xclk = ~xclk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model of the host-visible state.
    logic [31:0] m_sh [4];
    logic        m_dir;
    logic [7:0]  m_seq;
    logic        m_err;
    logic [31:0] m_ref, m_delta;

    typedef struct {
        logic [1:0]  cmd;
        logic [3:0]  addr;
        bit          scramble;
        bit          chk;
        logic [15:0] data;
        int          lat;
    } vec_t;
    vec_t tbl [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge xclk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_sh[i] = '0;
        m_dir = 0; m_seq = 0; m_err = 0; m_ref = 0; m_delta = 0;
    endtask

    task automatic model_snap();
        m_sh[0] = enc_period; m_sh[1] = enca_ontime;
        m_sh[2] = enci_period; m_sh[3] = enc_counts;
        m_dir   = enc_dir;
        m_seq   = m_seq + 8'd1;
        m_delta = enc_counts - m_ref;
        m_ref   = enc_counts;
    endtask

    function automatic logic [15:0] m_word(input logic [3:0] a);
        logic [31:0] w;
        if (a < 4'd8) begin
            w = m_sh[a / 2] >> (16 * (a % 2));
            return w[15:0];
        end
        if (a == 4'd8)
            return {m_seq, 4'b0000, m_err, auto_en, 1'b0, m_dir};
        if (DELTA_ON && (a == 4'd9 || a == 4'd10)) begin
            w = m_delta >> (16 * (a - 4'd9));
            return w[15:0];
        end
        return 16'h0000;
    endfunction

    task automatic model_op(input logic [1:0] cmd, input logic [3:0] addr, input bit poke,
                            output logic [15:0] exp);
        exp = '0;
        case (cmd)
            CMD_SNAP: model_snap();
            CMD_CLR:  m_ref = '0;
            CMD_RD: begin
                exp = m_word(addr);
                if (addr == 4'd8) m_err = 1'b0;
            end
            default: ;
        endcase
        if (poke) m_err = 1'b1;
    endtask

    // Issue one command; optionally poke a second request while busy.
    task automatic do_op(input logic [1:0] cmd, input logic [3:0] addr, input bit poke,
                         output int lat, output int pulse_n, output int busy_n);
        lat = -1; pulse_n = 0; busy_n = 0;
        host_req = 1'b1; host_cmd = cmd; host_addr = addr;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (i == 1) begin
                host_req = poke; host_cmd = CMD_SNAP; host_addr = 4'hF;
            end else begin
                host_req = 1'b0;
            end
            if (reset_enc_in_counts) pulse_n++;
            if (!host_ready) busy_n++;
            if (host_ack) begin
                lat = i;
                break;
            end
        end
        host_req = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] cmd, input logic [3:0] addr,
                          input bit poke);
        logic [15:0] exp;
        int lat, pn, bn, exp_lat;
        model_op(cmd, addr, poke, exp);
        do_op(cmd, addr, poke, lat, pn, bn);
        exp_lat = (cmd == CMD_CLR) ? CLR_P + 3 : (cmd == CMD_RSVD) ? 1 : 2;
        check({tag, " ack latency"}, lat, exp_lat);
        if (cmd == CMD_RD) check({tag, " rdata"}, host_rdata, exp);
        if (cmd == CMD_CLR) check({tag, " clear pulse width"}, pn, CLR_P);
    endtask

    task automatic scramble_inputs();
        enc_period  = $urandom; enca_ontime = $urandom;
        enci_period = $urandom; enc_counts  = $urandom;
        enc_dir     = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, pn, bn, snaps, last;
        logic [15:0] exp;
        logic [1:0] c;
        logic [3:0] a;

        tbl[0]  = '{CMD_SNAP, 4'd0,  1'b1, 1'b0, 16'h0000, 2};
        tbl[1]  = '{CMD_RD,   4'd0,  1'b0, 1'b1, 16'h5678, 2};
        tbl[2]  = '{CMD_RD,   4'd1,  1'b0, 1'b1, 16'h1234, 2};
        tbl[3]  = '{CMD_RD,   4'd7,  1'b0, 1'b1, 16'hFFFF, 2};
        tbl[4]  = '{CMD_RD,   4'd6,  1'b0, 1'b1, 16'hFFFE, 2};
        tbl[5]  = '{CMD_RD,   4'd2,  1'b0, 1'b1, 16'hCCDD, 2};
        tbl[6]  = '{CMD_RD,   4'd3,  1'b0, 1'b1, 16'hAABB, 2};
        tbl[7]  = '{CMD_RD,   4'd4,  1'b0, 1'b1, 16'hF00D, 2};
        tbl[8]  = '{CMD_RD,   4'd5,  1'b0, 1'b1, 16'h0BAD, 2};
        tbl[9]  = '{CMD_RD,   4'd8,  1'b0, 1'b1, 16'h0101, 2};
        tbl[10] = '{CMD_RD,   4'd15, 1'b0, 1'b1, 16'h0000, 2};
        tbl[11] = '{CMD_RD,   4'd0,  1'b0, 1'b1, 16'h5678, 2};
        tbl[12] = '{CMD_RSVD, 4'd0,  1'b0, 1'b1, 16'h5678, 1};
        tbl[13] = '{CMD_RD,   4'd9,  1'b0, 1'b1, T_D9, 2};
        tbl[14] = '{CMD_RD,   4'd10, 1'b0, 1'b1, T_D10, 2};
        tbl[15] = '{CMD_CLR,  4'd0,  1'b0, 1'b0, 16'h0000, CLR_P + 3};
        tbl[16] = '{CMD_RD,   4'd7,  1'b0, 1'b1, 16'hFFFF, 2};

        host_req = 0; host_cmd = 0; host_addr = 0; auto_en = 0; sample_interval = 0;
        enc_period = 32'h12345678; enca_ontime = 32'hAABBCCDD;
        enci_period = 32'h0BADF00D; enc_counts = 32'hFFFFFFFE; enc_dir = 1'b1;

        reset = 1'b0;
        repeat (3) step();
        check("reset host_ready", host_ready, 1);
        check("reset host_ack", host_ack, 0);
        check("reset clear pulse", reset_enc_in_counts, 0);
        check("reset host_rdata", host_rdata, 0);
        reset = 1'b1;
        step();
        model_reset();

        for (int i = 0; i < 17; i++) begin
            model_op(tbl[i].cmd, tbl[i].addr, 1'b0, exp);
            do_op(tbl[i].cmd, tbl[i].addr, 1'b0, lat, pn, bn);
            check($sformatf("vec%0d ack latency", i), lat, tbl[i].lat);
            if (tbl[i].chk) check($sformatf("vec%0d rdata", i), host_rdata, tbl[i].data);
            if (tbl[i].cmd == CMD_CLR) begin
                check($sformatf("vec%0d clear pulse width", i), pn, CLR_P);
                check($sformatf("vec%0d ready low cycles", i), bn, CLR_P + 2);
            end
            if (tbl[i].scramble) scramble_inputs();
        end

        // Request while busy in CLR sets sticky err; a status read clears it.
        run_op("busy clear", CMD_CLR, 4'd0, 1'b1);
        run_op("err status", CMD_RD, 4'd8, 1'b0);
        check("err bit set", host_rdata[3], 1);
        run_op("err status again", CMD_RD, 4'd8, 1'b0);
        check("err bit cleared", host_rdata[3], 0);
        run_op("busy snap", CMD_SNAP, 4'd0, 1'b1);
        run_op("busy snap status", CMD_RD, 4'd8, 1'b0);

        // Delta across snapshots and after a clear.
        enc_counts = 32'd100; run_op("delta snap100", CMD_SNAP, 4'd0, 1'b0);
        enc_counts = 32'd95;  run_op("delta snap95", CMD_SNAP, 4'd0, 1'b0);
        run_op("delta lo", CMD_RD, 4'd9, 1'b0);
        check("delta lo const", host_rdata, DELTA_ON ? 16'hFFFB : 16'h0000);
        run_op("delta hi", CMD_RD, 4'd10, 1'b0);
        check("delta hi const", host_rdata, DELTA_ON ? 16'hFFFF : 16'h0000);
        run_op("delta clear", CMD_CLR, 4'd0, 1'b0);
        enc_counts = 32'd7;   run_op("delta snap7", CMD_SNAP, 4'd0, 1'b0);
        run_op("delta after clr lo", CMD_RD, 4'd9, 1'b0);
        check("delta after clr const", host_rdata, DELTA_ON ? 16'h0007 : 16'h0000);
        run_op("delta after clr hi", CMD_RD, 4'd10, 1'b0);

        // Periodic auto snapshots every 10 clocks, never acked.
        sample_interval = 10; auto_en = 1'b1;
        snaps = 0; last = -1; bn = 0;
        for (int i = 1; i <= 55; i++) begin
            step();
            if (!host_ready) begin
                if (last >= 0) check("auto interval", i - last, 10);
                last = i;
                snaps++;
            end
            if (host_ack) bn++;
        end
        auto_en = 1'b0;
        repeat (2) step();
        check("auto snapshot count", snaps, 5);
        check("auto no ack", bn, 0);
        repeat (5) model_snap();
        run_op("auto status", CMD_RD, 4'd8, 1'b0);

        // Host read lands on the tick edge: read acked first, auto snap next.
        auto_en = 1'b1;
        repeat (9) step();
        exp = m_word(4'd1);
        host_req = 1'b1; host_cmd = CMD_RD; host_addr = 4'd1;
        step(); host_req = 1'b0;
        check("conflict in RD", host_ready, 0);
        step();
        check("conflict read ack", host_ack, 1);
        check("conflict read data", host_rdata, exp);
        step();
        check("conflict auto snap", host_ready, 0);
        check("conflict auto no ack", host_ack, 0);
        auto_en = 1'b0;
        model_snap();
        step();
        run_op("conflict status", CMD_RD, 4'd8, 1'b0);

        // Ticks during a long busy period: serviced after, second tick drops.
        sample_interval = 2; auto_en = 1'b1;
        do_op(CMD_CLR, 4'd0, 1'b0, lat, pn, bn);
        check("tick clr latency", lat, CLR_P + 3);
        step();
        check("pending serviced after clr", host_ready, 0);
        auto_en = 1'b0;
        repeat (3) step();
        do_op(CMD_RD, 4'd8, 1'b0, lat, pn, bn);
        check("drop err set", host_rdata[3], 1);
        check("status auto_en low", host_rdata[2], 0);
        do_op(CMD_RD, 4'd8, 1'b0, lat, pn, bn);
        check("drop err cleared", host_rdata[3], 0);

        // Asynchronous reset in the middle of a clear pulse.
        host_req = 1'b1; host_cmd = CMD_CLR; host_addr = 4'd0;
        step(); host_req = 1'b0;
        check("mid clr pulse high", reset_enc_in_counts, 1);
        #2 reset = 1'b0;
        #1;
        check("async reset pulse", reset_enc_in_counts, 0);
        check("async reset ready", host_ready, 1);
        check("async reset ack", host_ack, 0);
        check("async reset rdata", host_rdata, 0);
        repeat (2) step();
        check("held reset no ack", host_ack, 0);
        reset = 1'b1;
        step();
        model_reset();
        run_op("post reset status", CMD_RD, 4'd8, 1'b0);
        run_op("post reset shadow", CMD_RD, 4'd0, 1'b0);

        // snap_seq wrap 255 -> 0.
        for (int i = 0; i < 255; i++) run_op("wrap snap", CMD_SNAP, 4'd0, 1'b0);
        run_op("seq 255 status", CMD_RD, 4'd8, 1'b0);
        run_op("wrap last snap", CMD_SNAP, 4'd0, 1'b0);
        run_op("seq wrap status", CMD_RD, 4'd8, 1'b0);
        check("seq wrapped", host_rdata[15:8], 0);

        // Randomized host traffic against the model.
        for (int i = 0; i < 150; i++) begin
            int r;
            bit poke;
            scramble_inputs();
            r = $urandom_range(0, 9);
            a = 4'($urandom_range(0, 15));
            if (r <= 2)      c = CMD_SNAP;
            else if (r <= 6) c = CMD_RD;
            else if (r == 7) c = CMD_CLR;
            else if (r == 8) c = CMD_RSVD;
            else begin c = CMD_RD; a = 4'd8; end
            poke = (c != CMD_RSVD) && ($urandom_range(0, 5) == 0);
            run_op($sformatf("rand%0d", i), c, a, poke);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
